router_pkt_reg: RTL

Parametrised packet register stage for the router input path. It sits between the source port and the per-destination FIFOs. It captures and forwards header, payload and checksum bytes, and absorbs short `fifo_full` stalls in an in-order skid queue of configurable depth. It computes an XOR or additive checksum and checks both the checksum and the header length field, reporting errors once per packet. It replaces the single-byte-hold, XOR-only register stage and has its own packet state machine instead of consuming external FSM state strobes.

---
 rtl/router_pkg.sv | 29 ++
 rtl/router_pkt_reg_if.sv | 33 +++
 rtl/router_skid_fifo.sv | 54 +++++
 rtl/router_pkt_reg.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and header helpers for the router input path.
// Imported by the packet register stage and its bench.
package router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK
  } state_t;

  localparam int CHK_XOR = 0;
  localparam int CHK_SUM = 1;
  localparam int HDR_W   = 16;

  function automatic logic [HDR_W-1:0] hdr_addr(
    input logic [HDR_W-1:0] hdr,
    input int               addr_w
  );
    return hdr & ((HDR_W'(1) << addr_w) - HDR_W'(1));
  endfunction

  function automatic logic [HDR_W-1:0] hdr_len(
    input logic [HDR_W-1:0] hdr,
    input int               addr_w
  );
    return hdr >> addr_w;
  endfunction

endpackage

// File: rtl/router_pkt_reg_if.sv
// Source-side and FIFO-side signals of the packet register stage.
// The stage itself takes the slave view.
interface router_pkt_reg_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              pkt_valid;
  logic [DATA_W-1:0] din;
  logic              fifo_full;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              low_pkt_valid;
  logic              parity_done;
  logic              err_parity;
  logic              err_len;
  logic              err_ovf;

  modport master (
    output pkt_valid, din, fifo_full,
    input  dout, dout_valid, addr, busy,
    input  low_pkt_valid, parity_done,
    input  err_parity, err_len, err_ovf
  );

  modport slave (
    input  pkt_valid, din, fifo_full,
    output dout, dout_valid, addr, busy,
    output low_pkt_valid, parity_done,
    output err_parity, err_len, err_ovf
  );
endinterface

// File: rtl/router_skid_fifo.sv
// In-order skid queue absorbing short downstream stalls.
// Circular pointers; push and pop may coincide even when full.
module router_skid_fifo #(
  parameter  int DATA_W     = 8,
  parameter  int SKID_DEPTH = 2,
  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1,
  localparam int CNT_W = $clog2(SKID_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem [SKID_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(SKID_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wrap_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/router_pkt_reg.sv
// Packet register stage: forwards bytes through a skid queue and
// checks checksum and length once per packet.
module router_pkt_reg
  import router_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 2,
  parameter int SKID_DEPTH = 2,
  parameter int CHK_MODE   = CHK_XOR
) (
  input logic              clk,
  input logic              resetn,
  router_pkt_reg_if.slave  bus
);
  localparam int LEN_W = DATA_W - ADDR_W;
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  state_t            state;
  state_t            state_n;
  logic              hdr_acc;
  logic              pay_acc;
  logic              sum_acc;
  logic              do_check;
  logic              acc;
  logic [DATA_W-1:0] chk;
  logic [DATA_W-1:0] chk_in;
  logic [DATA_W-1:0] chk_next;
  logic [DATA_W-1:0] sum_byte;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  pcnt;
  logic              q_push;
  logic              q_pop;
  logic              q_full;
  logic              q_empty;
  logic [DATA_W-1:0] q_head;
  logic [CNT_W-1:0]  q_count;
  logic              drop;

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n  = state;
    hdr_acc  = 1'b0;
    pay_acc  = 1'b0;
    sum_acc  = 1'b0;
    do_check = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.pkt_valid) begin
          hdr_acc = 1'b1;
          state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.pkt_valid) begin
          pay_acc = 1'b1;
        end else begin
          sum_acc = 1'b1;
          state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        do_check = 1'b1;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign acc = hdr_acc | pay_acc | sum_acc;

  // Queue is bypassed only when empty and the FIFO can take the byte.
  assign q_pop  = ~bus.fifo_full & ~q_empty;
  assign q_push = acc & (bus.fifo_full ? ~q_full : ~q_empty);
  assign drop   = acc & bus.fifo_full & q_full;

  assign bus.busy = (state == ST_CHECK) |
                    (q_count == CNT_W'(SKID_DEPTH));

  always_comb begin
    chk_in   = hdr_acc ? '0 : chk;
    chk_next = (CHK_MODE == CHK_SUM) ? chk_in + bus.din
                                     : chk_in ^ bus.din;
  end

  router_skid_fifo #(
    .DATA_W     (DATA_W),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk    (clk),
    .resetn (resetn),
    .push   (q_push),
    .pop    (q_pop),
    .din    (bus.din),
    .head   (q_head),
    .count  (q_count),
    .full   (q_full),
    .empty  (q_empty)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.dout          <= '0;
      bus.dout_valid    <= 1'b0;
      bus.addr          <= '0;
      bus.low_pkt_valid <= 1'b0;
      bus.parity_done   <= 1'b0;
      bus.err_parity    <= 1'b0;
      bus.err_len       <= 1'b0;
      bus.err_ovf       <= 1'b0;
      chk               <= '0;
      sum_byte          <= '0;
      len               <= '0;
      pcnt              <= '0;
    end else begin
      bus.dout_valid <= ~bus.fifo_full & (acc | ~q_empty);
      if (!bus.fifo_full) begin
        if (!q_empty) bus.dout <= q_head;
        else if (acc) bus.dout <= bus.din;
      end
      if (hdr_acc) begin
        bus.addr <= ADDR_W'(hdr_addr(HDR_W'(bus.din), ADDR_W));
        len      <= LEN_W'(hdr_len(HDR_W'(bus.din), ADDR_W));
        chk      <= chk_next;
        pcnt     <= '0;
        bus.low_pkt_valid <= 1'b0;
        bus.parity_done   <= 1'b0;
        bus.err_parity    <= 1'b0;
        bus.err_len       <= 1'b0;
        bus.err_ovf       <= drop;
      end else begin
        if (pay_acc) begin
          chk <= chk_next;
          if (pcnt != '1) pcnt <= pcnt + LEN_W'(1);
        end
        if (sum_acc) begin
          sum_byte          <= bus.din;
          bus.low_pkt_valid <= 1'b1;
        end
        if (drop) bus.err_ovf <= 1'b1;
        if (do_check) begin
          bus.err_len     <= (pcnt != len);
          bus.err_parity  <= (chk != sum_byte);
          bus.parity_done <= 1'b1;
        end
      end
    end
  end

endmodule
